axi4lite_arbiter_2to1: RTL and testbench
========================================

AXI4LITE_ARBITER_2TO1 -- requirements
Module: axi4lite_arbiter_2to1

Interface
REQ-001 The module SHALL have parameter AW, default 32, giving the address width of all three AXI4-Lite ports.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port s0, Axi4LiteIf.slave, AW: requester 0, which has priority after reset.
REQ-005 The module SHALL have port s1, Axi4LiteIf.slave, AW: requester 1.
REQ-006 The module SHALL have port m, Axi4LiteIf.master, AW: the shared downstream slave.
REQ-007 The module SHALL have port grant, output, 2 bits: one-hot owner {s1,s0}; 00 when idle.
REQ-008 The module SHALL have port busy, output, 1 bit: high whenever the FSM is outside IDLE.

Function
REQ-009 Only one transaction SHALL be outstanding on m at a time, either one write or one read.
REQ-010 There SHALL be four request sources, in round-robin order s0W, s0R, s1W, s1R.
- xW requests when x.awvalid && x.wvalid.
- xR requests when x.arvalid.
REQ-011 On any arbitration win, the round-robin pointer SHALL move to the source after the winner. At reset the pointer SHALL be s0W.
REQ-012 The FSM states SHALL be IDLE, WR_ADDR, WR_RESP, RD_ADDR and RD_RESP.
REQ-013 In IDLE, when any source requests, the FSM SHALL register the winner and go to WR_ADDR or RD_ADDR.
- One-cycle latency: request in cycle N gives m.awvalid or m.arvalid in cycle N+1.
- No request: stay in IDLE.
REQ-014 In WR_ADDR, the granted requester's awaddr, awprot, awvalid, wdata, wstrb and wvalid SHALL pass combinationally to m. m.awready and m.wready SHALL route back to that requester.
REQ-015 The AW and W handshakes SHALL be tracked by the flags aw_done and w_done.
- Each channel's forwarded valid SHALL be masked once its flag is set.
- When both flags are set, including both in the same cycle, the FSM SHALL go to WR_RESP.
REQ-016 In WR_RESP, m.bvalid and m.bresp SHALL route to the owner and the owner's bready SHALL route to m. On b handshake the FSM SHALL go to IDLE and clear both flags.
REQ-017 In RD_ADDR, araddr, arprot and arvalid SHALL be forwarded and arready returned. On ar handshake the FSM SHALL go to RD_RESP.
REQ-018 In RD_RESP, rdata, rresp and rvalid SHALL route to the owner and rready to m. On r handshake the FSM SHALL go to IDLE.
REQ-019 The non-granted requester SHALL see awready=wready=arready=bvalid=rvalid=0 at all times.
REQ-020 In IDLE, all m valids and readys (awvalid, wvalid, arvalid, bready, rready) SHALL be 0.
REQ-021 Response data and resp fields SHALL pass through unmodified. The arbiter SHALL generate no error responses.
REQ-022 Back-to-back operation: after returning to IDLE, the next grant SHALL be decided in that IDLE cycle. A grant therefore recurs at most every 1+handshake cycles.
REQ-023 If a requester withdraws valid mid-transaction (a protocol violation), the FSM SHALL hold its state. No recovery is defined.
REQ-024 When s0 and s1 request in the same IDLE cycle, the pointer SHALL decide. Neither source SHALL wait more than 3 grants while continuously requesting.

Reset
REQ-025 Reset SHALL asynchronously force: state=IDLE, pointer=s0W, aw_done=w_done=0, owner cleared.
- All m valids and readys 0, grant=00, busy=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction. The downstream slave SHALL be reset by the same system reset.

Structure
REQ-027 The FSM state enum and the request-source enum SHALL live in a shared package, arb_pkg. axi_prot_t and axi_resp_t SHALL come from Axi_pkg.
REQ-028 The 4-way round-robin pointer and grant logic SHALL be one sub-module, rr_arbiter4. Its inputs are req[3:0] and advance; its outputs are a one-hot gnt[3:0] and the pointer.

Verification
REQ-029 Single write: s0 write to addr 0x10 with data 0xA5A5A5A5 -> m.awaddr=0x10 one cycle later, s0 receives bresp OKAY, grant=01 during the transaction, then 00.
REQ-030 Contention: s0W and s1R asserted in the same cycle after reset -> s0W served first, then s1R. Order repeated on sustained requests: s0W, s1R, s0W, s1R.
REQ-031 Full rotation: all four sources requesting continuously -> grant order s0W, s0R, s1W, s1R, s0W.
REQ-032 Split handshake: m.awready in cycle 1 and m.wready in cycle 3 -> exactly one AW and one W beat on m, no duplicate awvalid after cycle 1, then WR_RESP.
REQ-033 Isolation: s1 read pending while s0 owns the bus with slave rvalid=1 -> s1.rvalid=0 and s1.arready=0 throughout.
REQ-034 Reset in WR_RESP: assert reset -> busy=0, grant=00, m.bready=0 immediately. After release, the first s1R request is still served after the s0W pointer position.

Source files
------------

// File: rtl/axi4lite_arbiter_2to1_pkg.sv
// Shared AXI4-Lite field types and arbiter enums/helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Axi_pkg : data width, protection and response field types.
// arb_pkg : FSM state enum, request-source enum, one-hot decode helpers.

package Axi_pkg;

    localparam int DATA_W = 32;

    typedef logic [2:0] axi_prot_t;
    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

endpackage

package arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_RESP = 3'd4
    } arb_state_e;

    // Encoding order is the round-robin order; the pointer wraps 3 -> 0.
    typedef enum logic [1:0] {
        SRC_S0W = 2'd0,
        SRC_S0R = 2'd1,
        SRC_S1W = 2'd2,
        SRC_S1R = 2'd3
    } arb_src_e;

    // Input is expected to be one-hot (or zero, which maps to SRC_S0W).
    function automatic arb_src_e src_from_onehot(input logic [3:0] oh);
        arb_src_e s;
        s = SRC_S0W;
        if (oh[1]) s = SRC_S0R;
        if (oh[2]) s = SRC_S1W;
        if (oh[3]) s = SRC_S1R;
        return s;
    endfunction

    function automatic logic src_is_write(input arb_src_e s);
        return (s == SRC_S0W) || (s == SRC_S1W);
    endfunction

    function automatic logic src_is_s1(input arb_src_e s);
        return (s == SRC_S1W) || (s == SRC_S1R);
    endfunction

endpackage

// File: rtl/axi4lite_arbiter_2to1_if.sv
// AXI4-Lite bundle (AW/W/B/AR/R) with master and slave views.
// Latency: n/a (wiring only).
// Backpressure: standard per-channel valid/ready.
//
// Parameter AW: address width. Data width comes from Axi_pkg::DATA_W.
// master modport drives requests (addr/data/valids, bready/rready);
// slave modport drives readys and responses.

interface Axi4LiteIf #(
    parameter int AW = 32
);
    import Axi_pkg::*;

    logic [AW-1:0]       awaddr;
    axi_prot_t           awprot;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;

    axi_resp_t           bresp;
    logic                bvalid;
    logic                bready;

    logic [AW-1:0]       araddr;
    axi_prot_t           arprot;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    axi_resp_t           rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/axi4lite_arbiter_2to1_rr_arbiter4.sv
// Four-way round-robin arbiter: combinational one-hot grant searched from the pointer.
// Latency: grant is combinational; pointer updates on the clock after an advance.
// Backpressure: none; the caller only pulses advance when it accepts the grant.
//
// Ports: clk, reset (async, active-high), req[3:0], advance,
//        gnt[3:0] (one-hot, zero when no request), ptr (highest-priority source).

module rr_arbiter4
    import arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [3:0] req,
    input  logic     advance,
    output logic [3:0] gnt,
    output arb_src_e ptr
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;
    logic [1:0] win_idx;

    // Walk the four sources starting at the pointer; first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + i[1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves to the source just after the winner (wraps naturally).
    always_comb begin
        win_idx = src_from_onehot(gnt);
        ptr_d   = ptr_q;
        if (advance && found) begin
            ptr_d = win_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= SRC_S0W;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = arb_src_e'(ptr_q);

endmodule

// File: rtl/axi4lite_arbiter_2to1.sv
// Two-requester AXI4-Lite arbiter, one outstanding write or read on m at a time.
// Latency: request in cycle N -> m.awvalid/m.arvalid in N+1; channels then pass through combinationally.
// Backpressure: m readys route only to the owner; the other requester sees all readys/valids low.
//
// Ports: clk, reset (async, active-high), s0/s1 (requesters, slave view),
//        m (downstream, master view), grant[1:0] one-hot owner {s1,s0}, busy (FSM not IDLE).

module axi4lite_arbiter_2to1
    import arb_pkg::*;
    import Axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic       clk,
    input  logic       reset,
    Axi4LiteIf.slave   s0,
    Axi4LiteIf.slave   s1,
    Axi4LiteIf.master  m,
    output logic [1:0] grant,
    output logic       busy
);

    arb_state_e state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [3:0] req;
    logic [3:0] gnt;
    logic       advance;
    arb_src_e   win_src;

    logic       own_s1;
    logic       st_wr_addr, st_wr_resp, st_rd_addr, st_rd_resp;

    logic [AW-1:0] awaddr_sel, araddr_sel;
    logic       aw_fwd_vld, w_fwd_vld, ar_fwd_vld;
    logic       b_fwd_rdy, r_fwd_rdy;
    logic       aw_rdy_ret, w_rdy_ret, ar_rdy_ret;
    logic       b_vld_ret, r_vld_ret;
    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req[SRC_S0W] = s0.awvalid && s0.wvalid;
    assign req[SRC_S0R] = s0.arvalid;
    assign req[SRC_S1W] = s1.awvalid && s1.wvalid;
    assign req[SRC_S1R] = s1.arvalid;

    assign advance = (state_q == ST_IDLE) && (|req);
    assign win_src = src_from_onehot(gnt);

    rr_arbiter4 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .gnt     (gnt),
        .ptr     ()
    );

    // ------------------------------------------------------------------
    // State decode and owner select
    // ------------------------------------------------------------------
    assign own_s1     = owner_q[1];
    assign st_wr_addr = (state_q == ST_WR_ADDR);
    assign st_wr_resp = (state_q == ST_WR_RESP);
    assign st_rd_addr = (state_q == ST_RD_ADDR);
    assign st_rd_resp = (state_q == ST_RD_RESP);

    // ------------------------------------------------------------------
    // Requester -> m
    // Payload follows the owner unconditionally; only valids/readys are gated.
    // ------------------------------------------------------------------
    assign awaddr_sel = own_s1 ? s1.awaddr : s0.awaddr;
    assign araddr_sel = own_s1 ? s1.araddr : s0.araddr;

    assign m.awaddr = awaddr_sel;
    assign m.awprot = own_s1 ? s1.awprot : s0.awprot;
    assign m.wdata  = own_s1 ? s1.wdata  : s0.wdata;
    assign m.wstrb  = own_s1 ? s1.wstrb  : s0.wstrb;
    assign m.araddr = araddr_sel;
    assign m.arprot = own_s1 ? s1.arprot : s0.arprot;

    // A channel that already handshaked stays quiet so the slave sees exactly one beat.
    assign aw_fwd_vld = st_wr_addr && !aw_done_q && (own_s1 ? s1.awvalid : s0.awvalid);
    assign w_fwd_vld  = st_wr_addr && !w_done_q  && (own_s1 ? s1.wvalid  : s0.wvalid);
    assign ar_fwd_vld = st_rd_addr && (own_s1 ? s1.arvalid : s0.arvalid);
    assign b_fwd_rdy  = st_wr_resp && (own_s1 ? s1.bready  : s0.bready);
    assign r_fwd_rdy  = st_rd_resp && (own_s1 ? s1.rready  : s0.rready);

    assign m.awvalid = aw_fwd_vld;
    assign m.wvalid  = w_fwd_vld;
    assign m.arvalid = ar_fwd_vld;
    assign m.bready  = b_fwd_rdy;
    assign m.rready  = r_fwd_rdy;

    // ------------------------------------------------------------------
    // m -> requesters (only the owner sees readys/valids)
    // ------------------------------------------------------------------
    assign aw_rdy_ret = st_wr_addr && !aw_done_q && m.awready;
    assign w_rdy_ret  = st_wr_addr && !w_done_q  && m.wready;
    assign ar_rdy_ret = st_rd_addr && m.arready;
    assign b_vld_ret  = st_wr_resp && m.bvalid;
    assign r_vld_ret  = st_rd_resp && m.rvalid;

    assign s0.awready = owner_q[0] && aw_rdy_ret;
    assign s0.wready  = owner_q[0] && w_rdy_ret;
    assign s0.arready = owner_q[0] && ar_rdy_ret;
    assign s0.bvalid  = owner_q[0] && b_vld_ret;
    assign s0.rvalid  = owner_q[0] && r_vld_ret;
    assign s0.bresp   = m.bresp;
    assign s0.rdata   = m.rdata;
    assign s0.rresp   = m.rresp;

    assign s1.awready = owner_q[1] && aw_rdy_ret;
    assign s1.wready  = owner_q[1] && w_rdy_ret;
    assign s1.arready = owner_q[1] && ar_rdy_ret;
    assign s1.bvalid  = owner_q[1] && b_vld_ret;
    assign s1.rvalid  = owner_q[1] && r_vld_ret;
    assign s1.bresp   = m.bresp;
    assign s1.rdata   = m.rdata;
    assign s1.rresp   = m.rresp;

    // ------------------------------------------------------------------
    // Handshakes seen on m
    // ------------------------------------------------------------------
    assign aw_hs = aw_fwd_vld && m.awready;
    assign w_hs  = w_fwd_vld  && m.wready;
    assign ar_hs = ar_fwd_vld && m.arready;
    assign b_hs  = m.bvalid   && b_fwd_rdy;
    assign r_hs  = m.rvalid   && r_fwd_rdy;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    owner_d = src_is_s1(win_src) ? 2'b10 : 2'b01;
                    state_d = src_is_write(win_src) ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // Covers both orderings and the same-cycle case.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d   = ST_IDLE;
                    owner_d   = 2'b00;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                    owner_d = 2'b00;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                owner_d   = 2'b00;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant = owner_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// Directed bench for axi4lite_arbiter_2to1: the bench plays both requesters and the downstream slave.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.

module tb_axi4lite_arbiter_2to1;
    import Axi_pkg::*;

    localparam int AW = 32;

    logic       clk;
    logic       reset;
    logic [1:0] grant;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int aw_beats = 0;
    int w_beats  = 0;

    logic [2:0] cont_exp [4];
    logic [2:0] rot_exp  [5];

    Axi4LiteIf #(.AW(AW)) s0_if ();
    Axi4LiteIf #(.AW(AW)) s1_if ();
    Axi4LiteIf #(.AW(AW)) m_if ();

    axi4lite_arbiter_2to1 #(.AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .s0    (s0_if),
        .s1    (s1_if),
        .m     (m_if),
        .grant (grant),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat counters on the downstream port.
    always @(posedge clk) begin
        if (m_if.awvalid && m_if.awready) aw_beats <= aw_beats + 1;
        if (m_if.wvalid && m_if.wready)   w_beats  <= w_beats + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 1'b0;
        s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wvalid = 1'b0; s0_if.bready = 1'b1;
        s0_if.araddr = '0; s0_if.arprot = '0; s0_if.arvalid = 1'b0; s0_if.rready = 1'b1;
        s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 1'b0;
        s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wvalid = 1'b0; s1_if.bready = 1'b1;
        s1_if.araddr = '0; s1_if.arprot = '0; s1_if.arvalid = 1'b0; s1_if.rready = 1'b1;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bresp = AXI_RESP_OKAY; m_if.bvalid = 1'b0;
        m_if.arready = 1'b0; m_if.rdata = '0; m_if.rresp = AXI_RESP_OKAY; m_if.rvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_wr(input bit who, input bit v, input logic [31:0] addr, input logic [31:0] data);
        if (!who) begin
            s0_if.awvalid = v; s0_if.wvalid = v; s0_if.awaddr = addr; s0_if.wdata = data; s0_if.wstrb = 4'hF;
        end else begin
            s1_if.awvalid = v; s1_if.wvalid = v; s1_if.awaddr = addr; s1_if.wdata = data; s1_if.wstrb = 4'hF;
        end
    endtask

    task automatic set_rd(input bit who, input bit v, input logic [31:0] addr);
        if (!who) begin
            s0_if.arvalid = v; s0_if.araddr = addr;
        end else begin
            s1_if.arvalid = v; s1_if.araddr = addr;
        end
    endtask

    // Waits (bounded) for a grant, records owner and direction, then completes it as the slave.
    task automatic serve(input string tag, output logic [1:0] g, output logic wr, output int lat);
        lat = 0;
        while (!busy && lat < 20) begin
            step();
            lat++;
        end
        g  = grant;
        wr = m_if.awvalid;
        if (!busy) begin
            chk({tag, "_grant_timeout"}, 64'(busy), 64'd1);
        end else if (wr) begin
            m_if.awready = 1'b1; m_if.wready = 1'b1;
            step();
            m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b1;
            step();
            m_if.bvalid = 1'b0;
        end else begin
            m_if.arready = 1'b1;
            step();
            m_if.arready = 1'b0; m_if.rvalid = 1'b1;
            step();
            m_if.rvalid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of run before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] g;
        logic       wr;
        int         lat;
        int         aw0;
        int         w0;

        cont_exp = '{3'b011, 3'b100, 3'b011, 3'b100};
        rot_exp  = '{3'b011, 3'b010, 3'b101, 3'b100, 3'b011};

        // ---------------- reset state ----------------
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant",   64'(grant),        64'd0);
        chk("rst_busy",    64'(busy),         64'd0);
        chk("rst_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("rst_wvalid",  64'(m_if.wvalid),  64'd0);
        chk("rst_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("rst_bready",  64'(m_if.bready),  64'd0);
        chk("rst_rready",  64'(m_if.rready),  64'd0);
        reset = 1'b0;

        // ---------------- single write from s0 ----------------
        step();
        set_wr(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5);
        #1;
        chk("wr_idle_awvalid", 64'(m_if.awvalid), 64'd0);
        chk("wr_idle_grant",   64'(grant),        64'd0);
        step();
        chk("wr_awvalid",    64'(m_if.awvalid),    64'd1);
        chk("wr_awaddr",     64'(m_if.awaddr),     64'h10);
        chk("wr_wvalid",     64'(m_if.wvalid),     64'd1);
        chk("wr_wdata",      64'(m_if.wdata),      64'hA5A5_A5A5);
        chk("wr_grant",      64'(grant),           64'd1);
        chk("wr_busy",       64'(busy),            64'd1);
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("wr_s0_awready", 64'(s0_if.awready),   64'd1);
        chk("wr_s0_wready",  64'(s0_if.wready),    64'd1);
        chk("wr_s1_awready", 64'(s1_if.awready),   64'd0);
        step();
        set_wr(1'b0, 1'b0, 32'h0, 32'h0);
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        m_if.bvalid = 1'b1; m_if.bresp = AXI_RESP_OKAY;
        #1;
        chk("wr_s0_bvalid",  64'(s0_if.bvalid),    64'd1);
        chk("wr_s0_bresp",   64'(s0_if.bresp),     64'(AXI_RESP_OKAY));
        chk("wr_s1_bvalid",  64'(s1_if.bvalid),    64'd0);
        chk("wr_m_bready",   64'(m_if.bready),     64'd1);
        chk("wr_resp_grant", 64'(grant),           64'd1);
        step();
        m_if.bvalid = 1'b0;
        #1;
        chk("wr_done_grant", 64'(grant),           64'd0);
        chk("wr_done_busy",  64'(busy),            64'd0);

        // ---------------- contention s0W vs s1R ----------------
        do_reset();
        set_wr(1'b0, 1'b1, 32'h20, 32'h1111_1111);
        set_rd(1'b1, 1'b1, 32'h30);
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("cont%0d", i), g, wr, lat);
            chk($sformatf("cont%0d_order", i), 64'({g, wr}), 64'(cont_exp[i]));
        end
        set_wr(1'b0, 1'b0, 32'h0, 32'h0);
        set_rd(1'b1, 1'b0, 32'h0);

        // ---------------- full rotation, back-to-back ----------------
        do_reset();
        set_wr(1'b0, 1'b1, 32'h100, 32'h0000_0001);
        set_rd(1'b0, 1'b1, 32'h104);
        set_wr(1'b1, 1'b1, 32'h200, 32'h0000_0002);
        set_rd(1'b1, 1'b1, 32'h204);
        for (int i = 0; i < 5; i++) begin
            serve($sformatf("rot%0d", i), g, wr, lat);
            chk($sformatf("rot%0d_order", i), 64'({g, wr}), 64'(rot_exp[i]));
            chk($sformatf("rot%0d_gap", i),   64'(lat),       64'd1);
        end
        set_wr(1'b0, 1'b0, 32'h0, 32'h0);
        set_rd(1'b0, 1'b0, 32'h0);
        set_wr(1'b1, 1'b0, 32'h0, 32'h0);
        set_rd(1'b1, 1'b0, 32'h0);

        // ---------------- split AW/W handshake ----------------
        do_reset();
        aw0 = aw_beats;
        w0  = w_beats;
        set_wr(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D);
        step();
        m_if.awready = 1'b1;
        #1;
        chk("split_c1_awvalid", 64'(m_if.awvalid),  64'd1);
        chk("split_c1_s0_wrdy", 64'(s0_if.wready),  64'd0);
        step();
        m_if.awready = 1'b0;
        #1;
        chk("split_c2_awvalid", 64'(m_if.awvalid),  64'd0);
        chk("split_c2_wvalid",  64'(m_if.wvalid),   64'd1);
        chk("split_c2_bready",  64'(m_if.bready),   64'd0);
        step();
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        #1;
        chk("split_c3_awvalid", 64'(m_if.awvalid),  64'd0);
        chk("split_c3_s0_awrdy", 64'(s0_if.awready), 64'd0);
        chk("split_c3_s0_wrdy", 64'(s0_if.wready),  64'd1);
        step();
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        #1;
        chk("split_resp_bready", 64'(m_if.bready),  64'd1);
        chk("split_resp_wvalid", 64'(m_if.wvalid),  64'd0);
        chk("split_aw_beats",    64'(aw_beats - aw0), 64'd1);
        chk("split_w_beats",     64'(w_beats - w0),   64'd1);
        set_wr(1'b0, 1'b0, 32'h0, 32'h0);
        m_if.bvalid = 1'b1;
        step();
        m_if.bvalid = 1'b0;
        #1;
        chk("split_idle_busy", 64'(busy), 64'd0);

        // ---------------- isolation of pending s1 read ----------------
        do_reset();
        set_rd(1'b0, 1'b1, 32'h50);
        set_rd(1'b1, 1'b1, 32'h60);
        step();
        m_if.arready = 1'b1;
        #1;
        chk("iso_grant",      64'(grant),          64'd1);
        chk("iso_araddr",     64'(m_if.araddr),    64'h50);
        chk("iso_s0_arready", 64'(s0_if.arready),  64'd1);
        chk("iso_s1_arready", 64'(s1_if.arready),  64'd0);
        step();
        set_rd(1'b0, 1'b0, 32'h0);
        m_if.rvalid = 1'b1; m_if.rdata = 32'hDEAD_BEEF; m_if.rresp = AXI_RESP_SLVERR;
        #1;
        chk("iso_s0_rvalid",  64'(s0_if.rvalid),   64'd1);
        chk("iso_s0_rdata",   64'(s0_if.rdata),    64'hDEAD_BEEF);
        chk("iso_s0_rresp",   64'(s0_if.rresp),    64'(AXI_RESP_SLVERR));
        chk("iso_s1_rvalid",  64'(s1_if.rvalid),   64'd0);
        chk("iso_s1_arready_resp", 64'(s1_if.arready), 64'd0);
        chk("iso_m_arvalid",  64'(m_if.arvalid),   64'd0);
        chk("iso_m_rready",   64'(m_if.rready),    64'd1);
        step();
        m_if.arready = 1'b0;
        #1;
        chk("iso_idle_s1_rvalid", 64'(s1_if.rvalid), 64'd0);
        chk("iso_idle_rready",    64'(m_if.rready),  64'd0);
        m_if.rvalid = 1'b0; m_if.rresp = AXI_RESP_OKAY;
        serve("iso_s1", g, wr, lat);
        chk("iso_s1_served", 64'({g, wr}), 64'(3'b100));
        set_rd(1'b1, 1'b0, 32'h0);

        // ---------------- reset in WR_RESP ----------------
        do_reset();
        set_wr(1'b1, 1'b1, 32'h70, 32'h1234_5678);
        step();
        chk("rwr_grant", 64'(grant), 64'd2);
        m_if.awready = 1'b1; m_if.wready = 1'b1;
        step();
        m_if.awready = 1'b0; m_if.wready = 1'b0;
        set_wr(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rwr_pre_bready", 64'(m_if.bready), 64'd1);
        chk("rwr_pre_busy",   64'(busy),        64'd1);
        reset = 1'b1;
        #1;
        chk("rwr_busy",   64'(busy),        64'd0);
        chk("rwr_grant0", 64'(grant),       64'd0);
        chk("rwr_bready", 64'(m_if.bready), 64'd0);
        step();
        reset = 1'b0;
        set_wr(1'b0, 1'b1, 32'h80, 32'h0000_00AA);
        set_rd(1'b1, 1'b1, 32'h90);
        serve("rwr_first", g, wr, lat);
        chk("rwr_first_order", 64'({g, wr}), 64'(3'b011));
        set_wr(1'b0, 1'b0, 32'h0, 32'h0);
        serve("rwr_second", g, wr, lat);
        chk("rwr_second_order", 64'({g, wr}), 64'(3'b100));
        set_rd(1'b1, 1'b0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
